store_formatter: RTL

STORE_FORMATTER -- requirements
Module: store_formatter

---
 rtl/store_formatter_if.sv | 22 ++
 rtl/store_formatter.sv | 67 ++++++
 2 files changed

// File: rtl/store_formatter_if.sv
// store_formatter_if: store request and formatted write beat handshake bundle
interface store_formatter_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [31:0] in_addr;
  logic [1:0]  in_size;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic [3:0]  out_be;
  logic        out_err;
  modport master (
    output in_valid, in_data, in_addr, in_size, out_ready,
    input  in_ready, out_valid, out_addr, out_data, out_be, out_err
  );
  modport slave (
    input  in_valid, in_data, in_addr, in_size, out_ready,
    output in_ready, out_valid, out_addr, out_data, out_be, out_err
  );
endinterface

// File: rtl/store_formatter.sv
// store_formatter: formats store requests into lane-replicated word beats behind a 2-entry skid buffer
// STORE_FMT_MISALIGN_TRAP_EN: defined -> misaligned halfword/word beats are flagged as errors
module store_formatter #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  store_formatter_if.slave     bus,
  output logic [ERR_CNT_W-1:0] err_count
);
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        err;
  } beat_t;
  beat_t f, o, s, o_n, s_n;
  logic o_v, s_v, o_v_n, s_v_n, acc, o_free, mis;
  logic [1:0] a, sz;
  logic [ERR_CNT_W-1:0] cnt_n;
  assign a = bus.in_addr[1:0];
  assign sz = bus.in_size;
  assign acc = bus.in_valid && !s_v;
`ifdef STORE_FMT_MISALIGN_TRAP_EN
  assign mis = (sz == 2'b01 && a[0]) || (sz == 2'b10 && a != 2'b00);
`else
  assign mis = 1'b0;
`endif
  // formatting of the incoming request; errored beats enable no lanes
  always_comb begin
    f.addr = {bus.in_addr[31:2], 2'b00};
    f.err = sz == 2'b11 || mis;
    f.data = sz == 2'b00 ? {4{bus.in_data[7:0]}} : sz == 2'b01 ? {2{bus.in_data[15:0]}} : bus.in_data;
    f.be = f.err ? 4'b0000 : sz == 2'b00 ? 4'b0001 << a : sz == 2'b01 ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  end
  // skid buffer steering: output refills from skid first, so order stays FIFO
  always_comb begin
    o_free = !o_v || bus.out_ready;
    o_v_n = o_free ? (s_v || acc) : o_v;
    o_n = o_free ? (s_v ? s : acc ? f : '0) : o;
    s_v_n = o_free ? (s_v && acc) : (s_v || acc);
    s_n = (acc && s_v_n) ? f : s_v_n ? s : '0;
    cnt_n = (acc && f.err && !(&err_count)) ? err_count + {{(ERR_CNT_W-1){1'b0}}, 1'b1} : err_count;
  end
  // buffer stages and saturating error counter
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      o_v <= 1'b0;
      s_v <= 1'b0;
      o <= '0;
      s <= '0;
      err_count <= '0;
    end else begin
      o_v <= o_v_n;
      s_v <= s_v_n;
      o <= o_n;
      s <= s_n;
      err_count <= cnt_n;
    end
  end
  assign bus.in_ready = !s_v;
  assign bus.out_valid = o_v;
  assign bus.out_addr = o.addr;
  assign bus.out_data = o.data;
  assign bus.out_be = o.be;
  assign bus.out_err = o.err;
endmodule
